// File: rtl/bp_pkg.sv
// Shared return-address-stack defaults, the checkpoint record layout, and a
// helper that reduces one cycle's push/pop request to a single stack operation.
package bp_pkg;

    localparam int RAS_DEPTH    = 16;
    localparam int RAS_XLEN     = 64;
    localparam int RAS_NUM_CKPT = 4;
    localparam int RAS_TOS_W    = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W    = RAS_TOS_W + 1;

    typedef struct packed {
        logic [RAS_TOS_W-1:0] tos;
        logic [RAS_CNT_W-1:0] count;
        logic [RAS_XLEN-1:0]  top_addr;
    } ras_ckpt_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } ras_op_e;

    // A push paired with a pop on a live stack replaces the top entry in place;
    // on an empty stack the pop has nothing to remove, so it is a plain push.
    function automatic ras_op_e ras_decode(input logic push,
                                           input logic pop,
                                           input logic empty);
        ras_op_e op;
        op = OP_IDLE;
        if (push && pop && !empty) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop && !empty) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_ckpt_file.sv
// Checkpoint slot storage for the return-address stack: one write port,
// an asynchronous read port, and per-slot valid bits cleared by reset.
module ras_ckpt_file #(
    parameter  int NUM_CKPT = 4,
    parameter  int W        = 8,
    localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [CKPT_W-1:0] i_wr_id,
    input  logic [W-1:0]      i_wr_data,
    input  logic [CKPT_W-1:0] i_rd_id,
    output logic [W-1:0]      o_rd_data,
    output logic              o_rd_valid
);

    logic [W-1:0]        r_payload [NUM_CKPT];
    logic [NUM_CKPT-1:0] w_valid;

    // Payloads are deliberately left out of reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (reset_n && i_wr_en) begin
            r_payload[i_wr_id] <= i_wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
            logic r_vld;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld <= 1'b0;
                end else if (i_wr_en && (i_wr_id == CKPT_W'(gi))) begin
                    r_vld <= 1'b1;
                end
            end

            assign w_valid[gi] = r_vld;
        end
    endgenerate

    assign o_rd_data  = r_payload[i_rd_id];
    assign o_rd_valid = w_valid[i_rd_id];

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack: circular buffer with saturating count and optional
// checkpoint/restore for mispredict repair (enabled by defining RAS_CKPT_EN).
module ras_ckpt
    import bp_pkg::*;
#(
    parameter  int DEPTH    = RAS_DEPTH,
    parameter  int XLEN     = RAS_XLEN,
    parameter  int NUM_CKPT = RAS_NUM_CKPT,
    localparam int CKPT_W   = $clog2(NUM_CKPT),
    localparam int TOS_W    = $clog2(DEPTH),
    localparam int CNT_W    = TOS_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [XLEN-1:0]   push_addr_i,
    input  logic              pop_i,
    output logic [XLEN-1:0]   top_addr_o,
    output logic              top_valid_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic              ckpt_i,
    input  logic [CKPT_W-1:0] ckpt_id_i,
    input  logic              restore_i,
    input  logic [CKPT_W-1:0] restore_id_i
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TOS_W-1:0] TOS_ONE  = TOS_W'(1);

    logic [TOS_W-1:0] r_tos;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_entry [DEPTH];

    logic [TOS_W-1:0] w_tos_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_wr_en;
    logic [TOS_W-1:0] w_wr_idx;
    logic [XLEN-1:0]  w_wr_data;
    logic             w_empty;
    logic             w_full;
    logic [XLEN-1:0]  w_top;
    ras_op_e          w_op;

    logic             w_restore_hit;
    logic [TOS_W-1:0] w_rs_tos;
    logic [CNT_W-1:0] w_rs_count;
    logic [XLEN-1:0]  w_rs_top;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_top   = r_entry[r_tos];
    assign w_op    = ras_decode(push_i, pop_i, w_empty);

`ifdef RAS_CKPT_EN
    localparam int PW = TOS_W + CNT_W + XLEN;

    logic [PW-1:0] w_ck_wr_data;
    logic [PW-1:0] w_ck_rd_data;
    logic          w_ck_rd_valid;
    logic          w_ck_wr_en;

    // The snapshot is taken from the pre-update state, so a same-cycle
    // push/pop is not part of it; a valid restore suppresses the checkpoint.
    assign w_ck_wr_data  = {r_tos, r_count, w_top};
    assign w_restore_hit = restore_i && w_ck_rd_valid;
    assign w_ck_wr_en    = ckpt_i && !w_restore_hit;
    assign {w_rs_tos, w_rs_count, w_rs_top} = w_ck_rd_data;

    ras_ckpt_file #(
        .NUM_CKPT (NUM_CKPT),
        .W        (PW)
    ) u_ckpt_file (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_en    (w_ck_wr_en),
        .i_wr_id    (ckpt_id_i),
        .i_wr_data  (w_ck_wr_data),
        .i_rd_id    (restore_id_i),
        .o_rd_data  (w_ck_rd_data),
        .o_rd_valid (w_ck_rd_valid)
    );
`else
    logic w_unused_ckpt;

    assign w_unused_ckpt = ^{ckpt_i, ckpt_id_i, restore_i, restore_id_i};
    assign w_restore_hit = 1'b0;
    assign w_rs_tos      = '0;
    assign w_rs_count    = '0;
    assign w_rs_top      = '0;
`endif

    always_comb begin
        w_tos_next   = r_tos;
        w_count_next = r_count;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_tos;
        w_wr_data    = push_addr_i;

        if (w_restore_hit) begin
            w_tos_next   = w_rs_tos;
            w_count_next = w_rs_count;
            w_wr_en      = 1'b1;
            w_wr_idx     = w_rs_tos;
            w_wr_data    = w_rs_top;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    // When full, tos+1 lands on the oldest entry and overwrites it.
                    w_tos_next = r_tos + TOS_ONE;
                    w_wr_en    = 1'b1;
                    w_wr_idx   = r_tos + TOS_ONE;
                    if (!w_full) begin
                        w_count_next = r_count + CNT_ONE;
                    end
                end
                OP_POP: begin
                    w_tos_next   = r_tos - TOS_ONE;
                    w_count_next = r_count - CNT_ONE;
                end
                OP_REPLACE: begin
                    w_wr_en = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tos   <= '0;
            r_count <= '0;
        end else begin
            r_tos   <= w_tos_next;
            r_count <= w_count_next;
        end
    end

    // Entry storage has no reset; writes are dropped while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr_en) begin
            r_entry[w_wr_idx] <= w_wr_data;
        end
    end

    assign top_addr_o  = w_empty ? '0 : w_top;
    assign top_valid_o = !w_empty;
    assign full_o      = w_full;
    assign count_o     = r_count;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios plus randomized traffic
// compared every cycle against a behavioural stack model kept in the bench.
module tb_ras_ckpt;
    import bp_pkg::*;

    localparam int DEPTH    = 16;
    localparam int XLEN     = 64;
    localparam int NUM_CKPT = 4;
    localparam int CKPT_W   = 2;
    localparam int CNT_W    = 5;
`ifdef RAS_CKPT_EN
    localparam bit CKPT_EN = 1'b1;
`else
    localparam bit CKPT_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              push_i;
    logic [XLEN-1:0]   push_addr_i;
    logic              pop_i;
    logic [XLEN-1:0]   top_addr_o;
    logic              top_valid_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;
    logic              ckpt_i;
    logic [CKPT_W-1:0] ckpt_id_i;
    logic              restore_i;
    logic [CKPT_W-1:0] restore_id_i;

    ras_ckpt #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .NUM_CKPT (NUM_CKPT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (push_i),
        .push_addr_i  (push_addr_i),
        .pop_i        (pop_i),
        .top_addr_o   (top_addr_o),
        .top_valid_o  (top_valid_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .ckpt_i       (ckpt_i),
        .ckpt_id_i    (ckpt_id_i),
        .restore_i    (restore_i),
        .restore_id_i (restore_id_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stack slots addressed by an integer top index.
    logic [XLEN-1:0] m_mem [DEPTH];
    int              m_tos;
    int              m_cnt;
    ras_ckpt_t       m_slot [NUM_CKPT];
    bit              m_slot_vld [NUM_CKPT];

    int n_checks;
    int n_errors;
    int n_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_top();
        return (m_cnt == 0) ? '0 : m_mem[m_tos];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".top"},   top_addr_o,          m_top());
        check({tag, ".valid"}, 64'(top_valid_o),    64'(m_cnt != 0));
        check({tag, ".full"},  64'(full_o),         64'(m_cnt == DEPTH));
        check({tag, ".count"}, 64'(count_o),        64'(m_cnt));
    endtask

    task automatic model_reset();
        m_tos = 0;
        m_cnt = 0;
        for (int i = 0; i < NUM_CKPT; i++) m_slot_vld[i] = 1'b0;
    endtask

    task automatic model_step(input bit push, input logic [XLEN-1:0] addr, input bit pop,
                              input bit ck, input int cid, input bit rs, input int rid);
        ras_ckpt_t snap;
        if (CKPT_EN && rs && m_slot_vld[rid]) begin
            m_tos = int'(m_slot[rid].tos);
            m_cnt = int'(m_slot[rid].count);
            m_mem[m_tos] = m_slot[rid].top_addr;
            return;
        end
        snap.tos      = RAS_TOS_W'(m_tos);
        snap.count    = RAS_CNT_W'(m_cnt);
        snap.top_addr = m_mem[m_tos];
        if (CKPT_EN && ck) begin
            m_slot[cid]     = snap;
            m_slot_vld[cid] = 1'b1;
        end
        if (push && (!pop || m_cnt == 0)) begin
            m_tos = (m_tos + 1) % DEPTH;
            m_mem[m_tos] = addr;
            if (m_cnt < DEPTH) m_cnt++;
        end else if (push && pop) begin
            m_mem[m_tos] = addr;
        end else if (pop && m_cnt > 0) begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_cnt--;
        end
    endtask

    task automatic step(input bit push, input logic [XLEN-1:0] addr, input bit pop,
                        input bit ck, input int cid, input bit rs, input int rid);
        push_i       = push;
        push_addr_i  = addr;
        pop_i        = pop;
        ckpt_i       = ck;
        ckpt_id_i    = CKPT_W'(cid);
        restore_i    = rs;
        restore_id_i = CKPT_W'(rid);
        @(posedge clk);
        model_step(push, addr, pop, ck, cid, rs, rid);
        #1;
        n_cyc++;
        $display("txn %0d push=%0b addr=%h pop=%0b ckpt=%0b/%0d restore=%0b/%0d -> top=%h cnt=%0d",
                 n_cyc, push, addr, pop, ck, cid, rs, rid, top_addr_o, count_o);
        check_outputs($sformatf("cyc%0d", n_cyc));
    endtask

    task automatic do_push(input logic [XLEN-1:0] addr);
        step(1'b1, addr, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_pop();
        step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic clear_inputs();
        push_i       = 1'b0;
        push_addr_i  = '0;
        pop_i        = 1'b0;
        ckpt_i       = 1'b0;
        ckpt_id_i    = '0;
        restore_i    = 1'b0;
        restore_id_i = '0;
    endtask

    // Asserted between clock edges; whatever requests are on the inputs stay
    // there across the reset edges and must be discarded.
    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] exp_top;
        n_checks = 0;
        n_errors = 0;
        n_cyc    = 0;
        reset_n  = 1'b0;
        clear_inputs();
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic push / pop
        do_push(64'h1000);
        do_push(64'h2000);
        do_push(64'h3000);
        check("basic.top3", top_addr_o, 64'h3000);
        check("basic.cnt3", 64'(count_o), 64'd3);
        do_pop();
        check("basic.top2", top_addr_o, 64'h2000);
        check("basic.cnt2", 64'(count_o), 64'd2);

        // Overflow wraps onto the oldest entry, then drain to empty
        apply_reset("ovf");
        for (int i = 1; i <= 17; i++) do_push(64'(i * 'h100));
        check("ovf.full", 64'(full_o), 64'd1);
        check("ovf.cnt", 64'(count_o), 64'd16);
        check("ovf.top", top_addr_o, 64'h1100);
        for (int i = 1; i <= 16; i++) begin
            do_pop();
            if (i == 15) check("ovf.last_top", top_addr_o, 64'h200);
        end
        check("ovf.empty_cnt", 64'(count_o), 64'd0);
        check("ovf.empty_top", top_addr_o, 64'd0);

        // Empty-stack corner cases
        apply_reset("empty");
        do_pop();
        check("empty.pop_cnt", 64'(count_o), 64'd0);
        step(1'b1, 64'h40, 1'b1, 1'b0, 0, 1'b0, 0);
        check("empty.pp_cnt", 64'(count_o), 64'd1);
        check("empty.pp_top", top_addr_o, 64'h40);
        step(1'b1, 64'h80, 1'b1, 1'b0, 0, 1'b0, 0);
        check("repl.cnt", 64'(count_o), 64'd1);
        check("repl.top", top_addr_o, 64'h80);

        // Checkpoint then restore after speculative pop/push
        apply_reset("ckpt");
        do_push(64'hA0);
        do_push(64'hB0);
        step(1'b0, '0, 1'b0, 1'b1, 2, 1'b0, 0);
        do_pop();
        do_push(64'hC0);
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, 2);
        exp_top = CKPT_EN ? 64'hB0 : 64'hC0;
        check("restore.top", top_addr_o, exp_top);
        check("restore.cnt", 64'(count_o), 64'd2);
        do_pop();
        check("restore.pop_top", top_addr_o, 64'hA0);

        // Restore of a never-written slot is ignored; the push proceeds
        step(1'b1, 64'h55, 1'b0, 1'b0, 0, 1'b1, 3);
        check("badslot.top", top_addr_o, 64'h55);
        check("badslot.cnt", 64'(count_o), 64'd2);

        // Reset mid-stream with requests in flight, then restore must miss
        push_i      = 1'b1;
        push_addr_i = 64'hDEAD;
        restore_i   = 1'b1;
        apply_reset("midrst");
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, 2);
        check("midrst.restore_cnt", 64'(count_o), 64'd0);
        check("midrst.restore_valid", 64'(top_valid_o), 64'd0);

        // Randomized traffic including slot reuse and restore/ckpt collisions
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) < 45, {$urandom(), $urandom()},
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 15, int'($urandom_range(0, NUM_CKPT - 1)),
                 $urandom_range(0, 99) < 10, int'($urandom_range(0, NUM_CKPT - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
